pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It generates the execute-stage forwarding selects, load-use stalls and branch flushes for fetch/decode/execute. It also runs a halt/drain state machine that quiesces the pipeline on request without losing an instruction. Saturating stall and flush event counters are included for performance debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_forwarding_unit.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// execute-stage forward-select codes and the drain length.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Operand-mux select codes, also decoded by the execute-stage ALU input muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam logic [1:0]  DRAIN_LOAD   = 2'(DRAIN_CYCLES);

  // The younger producer (memory stage) wins over write-back; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forwarding_unit.sv
// Execute-stage operand forwarding selects, purely combinational from the
// E/M/W register fields.
module forwarding_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] RD_M,
  input  logic [4:0] RD_W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E
);

  assign ForwardA_E = fwd_sel(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
  assign ForwardB_E = fwd_sel(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use
// stalls, branch flushes, a halt/drain FSM and saturating event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, next_state;
  logic [1:0] drain_cnt, drain_cnt_nxt;
  logic       lw_stall;

  forwarding_unit u_fwd (
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .RD_M       (RD_M),
    .RD_W       (RD_W),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E)
  );

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    next_state    = state;
    drain_cnt_nxt = drain_cnt;
    StallF        = 1'b0;
    StallD        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    unique case (state)
      RUN: begin
        // A taken branch makes the decode instruction wrong-path, so it beats load-use.
        StallF = lw_stall && !PCSrcE;
        StallD = lw_stall && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        if (halt_req && !PCSrcE && !lw_stall) begin
          next_state    = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A late branch still redirects the PC and kills the held decode slot.
        StallF        = !PCSrcE;
        StallD        = !PCSrcE;
        FlushD        = PCSrcE;
        FlushE        = 1'b1;
        drain_cnt_nxt = drain_cnt - 2'd1;
        if (drain_cnt == 2'd1) next_state = HALTED;
      end
      HALTED: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (!halt_req) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halt_ack  <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_cnt_nxt;
      halt_ack  <= (next_state == HALTED);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (PCSrcE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
